// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//
// Shared types and constants for the gated edge-counting frequency meter.
//   freq_meter_state_t : measurement FSM states (ALIGN, MEASURE)
//   FILTER_LEN         : consecutive equal synchronized samples the optional
//                        glitch filter (FREQ_METER_GLITCH_FILTER_EN) needs
//                        before it moves its filtered level

package freq_meter_pkg;

   typedef enum logic {
      ALIGN   = 1'b0,
      MEASURE = 1'b1
   } freq_meter_state_t;

   localparam int FILTER_LEN = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//
// Brings an asynchronous signal into the clock domain and emits a one-cycle
// pulse for each rising edge of the (optionally filtered) synchronized level.
//
// Parameters:
//   SYNC_STAGES : synchronizer flip-flop stages (>= 2)
// Ports:
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   signal_in  : asynchronous input under measurement
//   edge_pulse : high for one cycle per detected rising edge
//
// Build option:
//   FREQ_METER_GLITCH_FILTER_EN : when defined, the synchronized level must be
//   stable for FILTER_LEN consecutive samples before the level used for edge
//   detection follows it, rejecting shorter pulses.

module sync_edge_detect
   import freq_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic signal_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_level;
   logic                   level;
   logic                   level_prev_q;

   // Plain shift-register synchronizer; bit 0 is the metastability-exposed
   // stage, the top bit is the first one safe to use.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      end
   end

   assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef FREQ_METER_GLITCH_FILTER_EN
   logic [FILTER_LEN-2:0] hist_q;
   logic                  filt_q;
   logic                  run_equal;

   // The current synchronized sample plus FILTER_LEN-1 previous samples
   // form the run; the filtered level only moves when the whole run agrees.
   always_comb begin
      run_equal = 1'b1;
      for (int i = 0; i < FILTER_LEN - 1; i++) begin
         if (hist_q[i] != sync_level) begin
            run_equal = 1'b0;
         end
      end
   end

   // Sample history and the filtered level itself.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q[0] <= sync_level;
         for (int i = 1; i < FILTER_LEN - 1; i++) begin
            hist_q[i] <= hist_q[i-1];
         end
         if (run_equal) begin
            filt_q <= sync_level;
         end
      end
   end

   assign level = filt_q;
`else
   assign level = sync_level;
`endif

   // One register of history turns a level rise into a single-cycle pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level;
      end
   end

   assign edge_pulse = level & ~level_prev_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//
// Gated edge-counting frequency meter. Rising edges of signal_in are counted
// over a window of GATE_TICKS timebase strobes; each completed window is
// presented through a valid/ready result port. Windows run back to back.
//
// Parameters:
//   GATE_TICKS  : tick strobes per measurement window (>= 1)
//   COUNT_WIDTH : width of the edge count and result
//   SYNC_STAGES : input synchronizer stages (>= 2)
// Ports:
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   enable       : measurement enable; low holds the meter in ALIGN
//   tick         : one-cycle timebase strobe
//   signal_in    : asynchronous signal under measurement
//   result       : edge count of the last completed window
//   overflow     : edge count saturated during that window
//   overrun      : previous result was overwritten before being accepted
//   result_valid : result/overflow/overrun are valid
//   result_ready : consumer accepts the result
//
// Build option:
//   FREQ_METER_GLITCH_FILTER_EN : enables the input glitch filter inside
//   sync_edge_detect (adds FILTER_LEN clocks of input latency).

module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_TICKS  = 1000,
   parameter int COUNT_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   tick,
   input  logic                   signal_in,
   output logic [COUNT_WIDTH-1:0] result,
   output logic                   overflow,
   output logic                   overrun,
   output logic                   result_valid,
   input  logic                   result_ready
);

   localparam int TICK_W = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
   localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(GATE_TICKS - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   freq_meter_state_t      state_q;
   freq_meter_state_t      state_d;
   logic [TICK_W-1:0]      tick_cnt_q;
   logic [COUNT_WIDTH-1:0] edge_cnt_q;
   logic                   ovf_flag_q;

   logic                   edge_pulse;
   logic                   edge_inc;
   logic                   window_close;
   logic                   edge_at_max;
   logic [COUNT_WIDTH-1:0] edge_cnt_next;
   logic                   ovf_next;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge_detect (
      .clock     (clock),
      .reset_n   (reset_n),
      .signal_in (signal_in),
      .edge_pulse(edge_pulse)
   );

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ALIGN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the per-cycle counting decisions. Edges are only counted
   // while already measuring, so an edge in the ALIGN->MEASURE cycle is
   // dropped, while an edge in the closing-tick cycle belongs to the window
   // that closes. Dropping enable aborts even a closing tick.
   always_comb begin
      state_d      = state_q;
      edge_inc     = 1'b0;
      window_close = 1'b0;
      unique case (state_q)
         ALIGN: begin
            if (enable && tick) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!enable) begin
               state_d = ALIGN;
            end else begin
               edge_inc     = edge_pulse;
               window_close = tick && (tick_cnt_q == TICK_LAST);
            end
         end
         default: begin
            state_d = ALIGN;
         end
      endcase
   end

   // Saturating edge count and sticky overflow as they would be after this
   // cycle; the closing window latches these directly.
   always_comb begin
      edge_at_max   = (edge_cnt_q == COUNT_MAX);
      edge_cnt_next = edge_cnt_q;
      ovf_next      = ovf_flag_q;
      if (edge_inc) begin
         if (edge_at_max) begin
            ovf_next = 1'b1;
         end else begin
            edge_cnt_next = edge_cnt_q + COUNT_WIDTH'(1);
         end
      end
   end

   // Window counters. They sit at zero outside MEASURE and restart at zero
   // the cycle a window closes, so the next window has no gap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_flag_q <= 1'b0;
      end else if (state_q != MEASURE || !enable || window_close) begin
         tick_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_flag_q <= 1'b0;
      end else begin
         edge_cnt_q <= edge_cnt_next;
         ovf_flag_q <= ovf_next;
         if (tick) begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
         end
      end
   end

   // Result registers and handshake. A closing window always loads a fresh
   // result; overrun records whether the one it replaces was still pending
   // (not accepted in this same cycle). Acceptance only clears valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result       <= '0;
         overflow     <= 1'b0;
         overrun      <= 1'b0;
         result_valid <= 1'b0;
      end else if (window_close) begin
         result       <= edge_cnt_next;
         overflow     <= ovf_next;
         overrun      <= result_valid && !result_ready;
         result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
         result_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//
// Directed bench for freq_meter with GATE_TICKS=4 and a tick every 10 clocks
// (40-clock windows). A second instance with a narrow count width exercises
// saturation. Inputs change on the falling edge; outputs are sampled 1 time
// unit after the rising edge.

module tb_freq_meter;

`ifdef FREQ_METER_GLITCH_FILTER_EN
   localparam int SIG_PERIOD = 8;
   localparam int SMALL_W    = 2;
   localparam int GLITCH_EXP = 0;
`else
   localparam int SIG_PERIOD = 4;
   localparam int SMALL_W    = 3;
   localparam int GLITCH_EXP = 4;
`endif
   localparam int MAIN_EXP  = 40 / SIG_PERIOD;
   localparam int SMALL_MAX = (1 << SMALL_W) - 1;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               enable = 1'b0;
   logic               tick = 1'b0;
   logic               signal_in = 1'b0;
   logic               result_ready = 1'b0;
   logic [15:0]        result;
   logic               overflow;
   logic               overrun;
   logic               result_valid;
   logic [SMALL_W-1:0] small_result;
   logic               small_overflow;
   logic               small_overrun;
   logic               small_valid;

   int errors = 0;
   int checks = 0;
   int sig_mode = 0;
   int sig_cnt = 0;
   int tick_cnt = 0;

   freq_meter #(
      .GATE_TICKS (4),
      .COUNT_WIDTH(16),
      .SYNC_STAGES(2)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .tick        (tick),
      .signal_in   (signal_in),
      .result      (result),
      .overflow    (overflow),
      .overrun     (overrun),
      .result_valid(result_valid),
      .result_ready(result_ready)
   );

   freq_meter #(
      .GATE_TICKS (4),
      .COUNT_WIDTH(SMALL_W),
      .SYNC_STAGES(2)
   ) dut_small (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .tick        (tick),
      .signal_in   (signal_in),
      .result      (small_result),
      .overflow    (small_overflow),
      .overrun     (small_overrun),
      .result_valid(small_valid),
      .result_ready(result_ready)
   );

   always #5 clock = ~clock;

   // Free-running timebase and input generators, updated on the falling edge.
   // sig_mode: 0 = low, 1 = square wave of SIG_PERIOD, 2 = 1-clock pulse per 10.
   initial begin
      forever begin
         @(negedge clock);
         tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
         tick     = (tick_cnt == 0);
         sig_cnt  = sig_cnt + 1;
         case (sig_mode)
            1:       signal_in = ((sig_cnt % SIG_PERIOD) < (SIG_PERIOD / 2));
            2:       signal_in = ((sig_cnt % 10) == 0);
            default: signal_in = 1'b0;
         endcase
      end
   end

   // Hard stop if something stalls beyond every per-wait bound.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance clock by clock until result_valid is seen or the bound expires,
   // counting cycles and ticks observed on the way.
   task automatic wait_valid(input int max_cycles, output int cycles,
                             output int ticks, output bit ok);
      cycles = 0;
      ticks  = 0;
      ok     = 1'b0;
      while (cycles < max_cycles && !ok) begin
         @(posedge clock);
         #1;
         cycles++;
         if (tick) ticks++;
         if (result_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (result !== 16'd0) begin errors++; $display("[TB] FAIL reset_result: got %0d, expected 0", result); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b, expected 0", overflow); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %0b, expected 0", overrun); end
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b, expected 0", result_valid); end
      checks++;
      if (small_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_small_valid: got %0b, expected 0", small_valid); end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_count();
      int cyc, tk;
      bit ok;
      @(negedge clock);
      enable = 1'b1;
      result_ready = 1'b1;
      sig_mode = 1;
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL count_first_valid: got timeout, expected valid"); end
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (cyc !== 40) begin errors++; $display("[TB] FAIL count_period: got %0d cycles, expected 40", cyc); end
      checks++;
      if (result !== 16'(MAIN_EXP)) begin errors++; $display("[TB] FAIL count_result: got %0d, expected %0d", result, MAIN_EXP); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL count_overflow: got %0b, expected 0", overflow); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL count_overrun: got %0b, expected 0", overrun); end
      checks++;
      if (small_result !== SMALL_W'(SMALL_MAX)) begin errors++; $display("[TB] FAIL sat_result: got %0d, expected %0d", small_result, SMALL_MAX); end
      checks++;
      if (small_overflow !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow: got %0b, expected 1", small_overflow); end
      @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL count_valid_pulse: got %0b, expected 0", result_valid); end
   endtask

   task automatic test_overflow_clear();
      int cyc, tk;
      bit ok;
      @(negedge clock);
      sig_mode = 0;
      wait_valid(100, cyc, tk, ok);
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok || small_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear_valid: got ok=%0b small_valid=%0b, expected 1/1", ok, small_valid); end
      checks++;
      if (small_result !== SMALL_W'(0)) begin errors++; $display("[TB] FAIL clear_small_result: got %0d, expected 0", small_result); end
      checks++;
      if (small_overflow !== 1'b0) begin errors++; $display("[TB] FAIL clear_small_overflow: got %0b, expected 0", small_overflow); end
      checks++;
      if (result !== 16'd0) begin errors++; $display("[TB] FAIL clear_result: got %0d, expected 0", result); end
   endtask

   task automatic test_overrun();
      int cyc, tk;
      bit ok;
      bit held;
      logic [15:0] first;
      @(negedge clock);
      sig_mode = 1;
      wait_valid(100, cyc, tk, ok);
      wait_valid(100, cyc, tk, ok);
      @(negedge clock);
      result_ready = 1'b0;
      first = result;
      checks++;
      if (first !== 16'(MAIN_EXP) || overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_first: got result=%0d overrun=%0b, expected %0d/0", first, overrun, MAIN_EXP); end
      held = 1'b1;
      repeat (39) begin
         @(posedge clock);
         #1;
         if (result_valid !== 1'b1 || result !== first) held = 1'b0;
      end
      checks++;
      if (!held) begin errors++; $display("[TB] FAIL overrun_hold: got valid/result changed, expected stable"); end
      @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %0b, expected 1", result_valid); end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %0b, expected 1", overrun); end
      checks++;
      if (result !== 16'(MAIN_EXP)) begin errors++; $display("[TB] FAIL overrun_result: got %0d, expected %0d", result, MAIN_EXP); end
      @(negedge clock);
      result_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_accept: got %0b, expected 0", result_valid); end
      @(negedge clock);
      result_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc, tk;
      bit ok;
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok || overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first: got ok=%0b overrun=%0b, expected 1/0", ok, overrun); end
      repeat (39) @(posedge clock);
      @(negedge clock);
      result_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %0b, expected 1", result_valid); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %0b, expected 0", overrun); end
      checks++;
      if (result !== 16'(MAIN_EXP)) begin errors++; $display("[TB] FAIL b2b_result: got %0d, expected %0d", result, MAIN_EXP); end
      @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drop: got %0b, expected 0", result_valid); end
   endtask

   task automatic test_enable();
      int cyc, tk;
      bit ok;
      bit quiet;
      repeat (15) @(posedge clock);
      @(negedge clock);
      enable = 1'b0;
      quiet = 1'b1;
      repeat (60) begin
         @(posedge clock);
         #1;
         if (result_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin errors++; $display("[TB] FAIL enable_abort: got valid while disabled, expected none"); end
      @(negedge clock);
      enable = 1'b1;
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL enable_timeout: got timeout, expected valid"); end
      checks++;
      if (tk !== 5) begin errors++; $display("[TB] FAIL enable_ticks: got %0d, expected 5", tk); end
      checks++;
      if (result !== 16'(MAIN_EXP)) begin errors++; $display("[TB] FAIL enable_result: got %0d, expected %0d", result, MAIN_EXP); end
   endtask

   task automatic test_reset_mid();
      int cyc, tk;
      bit ok;
      @(negedge clock);
      result_ready = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b1 || small_overflow !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre: got valid=%0b small_ovf=%0b, expected 1/1", result_valid, small_overflow); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %0b, expected 0", result_valid); end
      checks++;
      if (result !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_result: got %0d, expected 0", result); end
      checks++;
      if (small_overflow !== 1'b0 || small_result !== SMALL_W'(0)) begin errors++; $display("[TB] FAIL rstmid_small: got ovf=%0b result=%0d, expected 0/0", small_overflow, small_result); end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      result_ready = 1'b1;
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok || tk !== 5) begin errors++; $display("[TB] FAIL rstmid_ticks: got ok=%0b ticks=%0d, expected 1/5", ok, tk); end
      checks++;
      if (result !== 16'(MAIN_EXP)) begin errors++; $display("[TB] FAIL rstmid_result_after: got %0d, expected %0d", result, MAIN_EXP); end
   endtask

   task automatic test_glitch();
      int cyc, tk;
      bit ok;
      @(negedge clock);
      sig_mode = 2;
      wait_valid(100, cyc, tk, ok);
      wait_valid(100, cyc, tk, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL glitch_timeout: got timeout, expected valid"); end
      checks++;
      if (result !== 16'(GLITCH_EXP)) begin errors++; $display("[TB] FAIL glitch_result: got %0d, expected %0d", result, GLITCH_EXP); end
   endtask

   initial begin
      $display("[TB] freq_meter bench start");
      test_reset();
      test_count();
      test_overflow_clear();
      test_overrun();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_glitch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter. It counts rising edges of an asynchronous input over a window of `GATE_TICKS` timebase strobes, then presents the count through a valid/ready result port. The timebase strobe is normally the carry output of a modulo prescaler counter, so this block sits downstream of the counter as the consumer of its carry ticks. It feeds display or readout logic in the lab designs.

## Interface
- `GATE_TICKS`, default 1000: `tick` strobes per measurement window; must be ≥1.
- `COUNT_WIDTH`, default 16: width of the edge count and result.
- `SYNC_STAGES`, default 2: flip-flop stages in the input synchronizer; must be ≥2.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: measurement enable. When low, the meter is held in ALIGN.
- `tick` input 1: one-cycle timebase strobe, synchronous to `clock`.
- `signal_in` input 1: asynchronous signal under measurement.
- `result` output COUNT_WIDTH: edge count of the last completed window.
- `overflow` output 1: the edge count saturated during the window that produced `result`.
- `overrun` output 1: the previous result was overwritten before it was accepted.
- `result_valid` output 1: `result`, `overflow` and `overrun` are valid.
- `result_ready` input 1: the consumer accepts the result.

## Operation
- Input path: `signal_in` passes through `SYNC_STAGES` flip-flops, then a one-register rising-edge detect. This produces `edge_pulse`, which is high for one cycle per rising edge.
- FSM, state ALIGN (reset state):
  - tick counter and edge counter are held at 0.
  - On `tick` with `enable` high, go to MEASURE.
  - The partial window before the first tick is discarded.
- FSM, state MEASURE:
  - `edge_pulse` increments the edge counter, saturating at 2^COUNT_WIDTH−1. Saturation sets the internal overflow flag.
  - `tick` increments the tick counter.
  - On a tick with tick counter = GATE_TICKS−1, the window closes:
    - latch `result`, `overflow` and `overrun`;
    - clear both counters and the overflow flag;
    - stay in MEASURE, so windows run back to back with no gap.
  - `enable` low goes to ALIGN and discards the partial window. The held result and `result_valid` are unaffected.
- Simultaneous events:
  - An `edge_pulse` in the closing-tick cycle counts toward the closing window. The new window starts at 0.
  - An `edge_pulse` in the ALIGN→MEASURE cycle is not counted.
- Handshake:
  - `result_valid` stays high until a cycle with `result_valid && result_ready`. It then falls on the next edge.
  - `result` is stable while `result_valid` is high and no window closes.
  - A window can close while `result_valid` is high and the result is not accepted in that same cycle. In that case the result is overwritten, `overrun`=1 and `result_valid` stays high.
  - If the old result is accepted in the same cycle that a window closes, the new result is latched with `overrun`=0 and `result_valid` stays high.
- Reset values (asynchronous, any time, including mid-window): all outputs 0, FSM in ALIGN, counters and synchronizer cleared.

## Timing
- Latency from input to count: a `signal_in` rise first sampled at edge k is counted at edge k+SYNC_STAGES.
- `result_valid` rises in the cycle after the closing-tick edge.
- Window length = GATE_TICKS tick periods, measured tick to tick.
- Maximum countable input frequency: clock/2. Input pulses shorter than one clock period can be missed.
- Nothing on the output side is combinational from inputs.

## Configuration
- `FREQ_METER_GLITCH_FILTER_EN` defined:
  - A filter after the synchronizer changes its filtered level only after 3 consecutive equal synchronized samples.
  - Edge detection operates on the filtered level.
  - Input-to-count latency becomes SYNC_STAGES+3.
  - Pulses shorter than 3 clocks are rejected.
- Undefined: no filter. The latency above applies and every synchronized level change is used.

## Structure
- `freq_meter_pkg` holds:
  - the FSM enum typedef `freq_meter_state_t` {ALIGN, MEASURE};
  - the localparam for the filter length (3).
- Sub-module `sync_edge_detect`: synchronizer, optional glitch filter and rising-edge pulse, parameterized by `SYNC_STAGES`.
- The top level holds the FSM, counters, result registers and handshake.

## Test plan
- Bench parameters: GATE_TICKS=4, tick every 10 clocks, `signal_in` period 4 clocks, `result_ready`=1 → `result`=10, `overflow`=0, one `result_valid` pulse every 40 clocks.
- COUNT_WIDTH=3 with the same stimulus → `result`=7, `overflow`=1. The next window with `signal_in` held low gives `result`=0, `overflow`=0.
- `result_ready`=0 across two windows → `result_valid` high continuously, second result has `overrun`=1. Raising ready for one cycle drops `result_valid`.
- `enable` pulled low mid-window, then raised → no result from the aborted window. The first result is a full 4-tick window (=10), starting at the first tick after re-enable.
- `reset_n` asserted mid-window → all outputs 0 immediately. After release, the first result arrives 4 ticks after the first tick.
- 1-clock-wide pulses on `signal_in` every 10 clocks → `result`=4 without `FREQ_METER_GLITCH_FILTER_EN`, `result`=0 with it.
